msk_unsharing: RTL and testbench

- Recombination block: takes a d-share Boolean sharing of a W-bit word and produces the unmasked word.
- Inverse counterpart of the share-generation logic. Used at the masked datapath boundary, e.g. ciphertext output.
- Shares are folded serially, one share per cycle, into a registered accumulator. No combinational XOR tree over all d shares ever exists.
- Valid/ready handshake on both sides.

---
 rtl/msk_unsharing.sv | 119 +++++++++++
 tb/tb_msk_unsharing.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_unsharing.sv
// msk_unsharing: serial recombination of a d-share Boolean sharing into a W-bit word.
// Optional MSK_UNSHARING_ZEROIZE_EN clears share/accumulator state after each transfer.
module msk_unsharing #(
    parameter int d = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [d*W-1:0] sh_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   data_out
);

    localparam int CW = $clog2(d);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [d*W-1:0]        share_q;
    logic [W-1:0]          acc_q;
    logic [W-1:0]          data_q;
    logic [CW-1:0]         cnt;
    logic [W-1:0]          fold_word;
    logic [d-1:0][W-1:0]   in_view;
    logic [d-1:0][W-1:0]   reg_view;
    logic                  last;
    logic                  accept;
    logic                  deliver;

    // Re-index the bit-sliced buses as one W-bit word per share.
    for (genvar i = 0; i < d; i++) begin : g_share
        for (genvar j = 0; j < W; j++) begin : g_bit
            assign in_view[i][j]  = sh_in[j*d+i];
            assign reg_view[i][j] = share_q[j*d+i];
        end
    end

    assign fold_word = reg_view[cnt];
    assign last      = (cnt == CW'(d-1));
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)  state_nxt = FOLD;
            FOLD: if (last)    state_nxt = OUT;
            OUT:  if (deliver) state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_q <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        share_q <= sh_in;
                        acc_q   <= in_view[0];
                        cnt     <= CW'(1);
                    end
                end
                FOLD: begin
                    acc_q <= acc_q ^ fold_word;
                    if (last) begin
                        cnt    <= '0;
                        data_q <= acc_q ^ fold_word;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUT: begin
`ifdef MSK_UNSHARING_ZEROIZE_EN
                    if (deliver) begin
                        share_q <= '0;
                        acc_q   <= '0;
                    end
`endif
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef MSK_UNSHARING_ZEROIZE_EN
    assign data_out = out_valid ? data_q : '0;
`else
    assign data_out = data_q;
`endif

endmodule

// File: tb/tb_msk_unsharing.sv
// tb_msk_unsharing: directed test of msk_unsharing (d=3, W=8) against a
// cycle-level behavioural model plus hand-computed expectations.
module tb_msk_unsharing;

    localparam int D = 3;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [D*W-1:0] sh_in = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   data_out;

    msk_unsharing #(.d(D), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sh_in    (sh_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [D*W-1:0] pack3(input logic [W-1:0] a, b, c);
        logic [W-1:0]   s [D];
        logic [D*W-1:0] r;
        s[0] = a;
        s[1] = b;
        s[2] = c;
        r = '0;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < W; j++)
                r[j*D+i] = s[i][j];
        return r;
    endfunction

    function automatic logic [D*W-1:0] rnd_share(input logic [W-1:0] word);
        logic [W-1:0] b, c;
        b = W'($urandom);
        c = W'($urandom);
        return pack3(word ^ b ^ c, b, c);
    endfunction

    // Reference: unmasked word is the XOR of every share of each bit.
    function automatic logic [W-1:0] unshare(input logic [D*W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < W; j++)
            for (int i = 0; i < D; i++)
                r[j] = r[j] ^ s[j*D+i];
        return r;
    endfunction

    logic         m_idle, m_out;
    logic [W-1:0] m_acc, m_data;
    int           m_left;
    int           cyc = 0;
    int           acc_t[$];
    logic [W-1:0] dut_words[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_out  <= 1'b0;
            m_acc  <= '0;
            m_data <= '0;
            m_left <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_acc  <= unshare(sh_in);
                m_left <= D - 1;
                m_idle <= 1'b0;
                acc_t.push_back(cyc);
            end
        end else if (!m_out) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_out  <= 1'b1;
                m_data <= m_acc;
            end
        end else if (out_ready) begin
            m_out  <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    logic [W-1:0] exp_data;
`ifdef MSK_UNSHARING_ZEROIZE_EN
    assign exp_data = m_out ? m_data : '0;
`else
    assign exp_data = m_data;
`endif

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_idle));
        chk("out_valid", 32'(out_valid), 32'(m_out));
        chk("data_out", 32'(data_out), 32'(exp_data));
        if (out_valid && out_ready) dut_words.push_back(data_out);
    end

    task automatic send(input logic [D*W-1:0] s);
        in_valid = 1'b1;
        sh_in    = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
            if (k == 49) begin
                errors++;
                checks++;
                $display("FAIL send_timeout in_ready=0 required=1");
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sh_in    = pack3(8'hDE, 8'hAD, 8'hBE);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) return;
        end
        errors++;
        checks++;
        $display("FAIL wait_out_timeout out_valid=0 required=1");
    endtask

    int n;
    int a0, w0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: 0x5A ^ 0xF0 ^ 0x00 = 0xAA
        out_ready = 1'b0;
        send(pack3(8'h5A, 8'hF0, 8'h00));
        wait_out(n);
        chk("basic_latency", n, D);
        chk("basic_data", 32'(data_out), 32'h AA);
        chk("basic_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("basic_back_idle", 32'(in_ready), 1);
        chk("basic_valid_drop", 32'(out_valid), 0);
`ifdef MSK_UNSHARING_ZEROIZE_EN
        chk("zeroize_data", 32'(data_out), 0);
        chk("zeroize_share_reg", 32'(dut.share_q), 0);
`else
        chk("stale_data", 32'(data_out), 32'h AA);
`endif

        // Backpressure: 0x11 ^ 0x22 ^ 0x44 = 0x77, in_valid pulses ignored
        w0 = dut_words.size();
        send(pack3(8'h11, 8'h22, 8'h44));
        wait_out(n);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = k[0];
            sh_in    = pack3(8'hFF, 8'h00, 8'h00);
            chk("bp_data", 32'(data_out), 32'h 77);
            chk("bp_valid", 32'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_back_idle", 32'(in_ready), 1);
        chk("bp_words", dut_words.size() - w0, 1);
        if (dut_words.size() == w0 + 1) chk("bp_word", 32'(dut_words[w0]), 32'h 77);

        // Back-to-back with random shares
        out_ready = 1'b1;
        a0 = acc_t.size();
        w0 = dut_words.size();
        send(rnd_share(8'h3C));
        send(rnd_share(8'hC3));
        wait_out(n);
        @(posedge clk);
        #1;
        chk("b2b_accepts", acc_t.size() - a0, 2);
        if (acc_t.size() == a0 + 2) chk("b2b_interval", acc_t[a0+1] - acc_t[a0], D + 1);
        chk("b2b_words", dut_words.size() - w0, 2);
        if (dut_words.size() == w0 + 2) begin
            chk("b2b_word0", 32'(dut_words[w0]), 32'h 3C);
            chk("b2b_word1", 32'(dut_words[w0+1]), 32'h C3);
        end

        // Reset during FOLD aborts the word
        w0 = dut_words.size();
        send(rnd_share(8'h99));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_data_out", 32'(data_out), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(rnd_share(8'h01));
        wait_out(n);
        @(posedge clk);
        #1;
        chk("abort_words", dut_words.size() - w0, 1);
        if (dut_words.size() == w0 + 1) chk("abort_word", 32'(dut_words[w0]), 32'h 01);

        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
